// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// arbiter FSM encodings, the latched-operation record and the round-robin pick.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  // ALU control codes shared by both requesters and the ALU itself.
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SOLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;

  // Arbiter FSM encodings, kept next to the ALU codes.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  // One accepted operation as held while it executes.
  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [CTRL_W-1:0] ctrl;
  } alu_req_t;

  // Two-way round-robin: a lone requester wins, a tie goes to the one that
  // did not win last time. Only meaningful when at least one valid is high.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return v1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus shared status, seen from
// the arbiter (slave) and from the requesters (master).
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  // Requester 0
  logic              i_req_valid_0;
  logic              o_req_ready_0;
  logic [DATA_W-1:0] i_op1_0;
  logic [DATA_W-1:0] i_op2_0;
  logic [CTRL_W-1:0] i_ctrl_0;
  logic              o_rsp_valid_0;
  logic              i_rsp_ready_0;

  // Requester 1
  logic              i_req_valid_1;
  logic              o_req_ready_1;
  logic [DATA_W-1:0] i_op1_1;
  logic [DATA_W-1:0] i_op2_1;
  logic [CTRL_W-1:0] i_ctrl_1;
  logic              o_rsp_valid_1;
  logic              i_rsp_ready_1;

  // Shared response data and status
  logic [DATA_W-1:0] o_rsp_result;
  logic              o_rsp_zf;
  logic              o_busy;
  logic              o_last_grant;

  modport slave (
    input  i_req_valid_0, i_op1_0, i_op2_0, i_ctrl_0, i_rsp_ready_0,
    input  i_req_valid_1, i_op1_1, i_op2_1, i_ctrl_1, i_rsp_ready_1,
    output o_req_ready_0, o_rsp_valid_0,
    output o_req_ready_1, o_rsp_valid_1,
    output o_rsp_result, o_rsp_zf, o_busy, o_last_grant
  );

  modport master (
    output i_req_valid_0, i_op1_0, i_op2_0, i_ctrl_0, i_rsp_ready_0,
    output i_req_valid_1, i_op1_1, i_op2_1, i_ctrl_1, i_rsp_ready_1,
    input  o_req_ready_0, o_rsp_valid_0,
    input  o_req_ready_1, o_rsp_valid_1,
    input  o_rsp_result, o_rsp_zf, o_busy, o_last_grant
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU: wrapping add/sub, bitwise ops and signed
// set-on-less-than. Unknown control codes produce zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [WIDTH-1:0]  i_op1,
  input  logic [WIDTH-1:0]  i_op2,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_zero
);

  logic signed_lt;

  assign signed_lt = ($signed(i_op1) < $signed(i_op2));

  // Operation select; the default keeps unknown codes harmless.
  always_comb begin
    unique case (i_ctrl)
      ALU_AND:  o_result = i_op1 & i_op2;
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_ADD:  o_result = i_op1 + i_op2;
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_SUB:  o_result = i_op1 - i_op2;
      ALU_SOLT: o_result = {{(WIDTH-1){1'b0}}, signed_lt};
      ALU_NOR:  o_result = ~(i_op1 | i_op2);
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters. A three-state FSM
// (IDLE -> EXEC -> RESP) accepts one operation at a time with round-robin
// priority and returns the registered result only to the granted requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  alu_req_t         req_q, req_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zf_q, rsp_zf_d;

  logic             grant_ok;
  logic             grant_idx;
  logic             rsp_ready_g;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Arbitration is combinational from the valids, state and last grant. It is
  // gated by reset so nothing is offered while the block is held in reset.
  assign grant_ok    = (state_q == ARB_IDLE) && i_rst_n &&
                       (bus.i_req_valid_0 || bus.i_req_valid_1);
  assign grant_idx   = rr_pick(bus.i_req_valid_0, bus.i_req_valid_1, last_grant_q);
  assign rsp_ready_g = grant_q ? bus.i_rsp_ready_1 : bus.i_rsp_ready_0;

  // The ALU only ever sees the latched operation, never the live inputs.
  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_ctrl   (req_q.ctrl),
    .i_op1    (req_q.op1),
    .i_op2    (req_q.op2),
    .o_result (alu_result),
    .o_zero   (alu_zero)
  );

  // State register: FSM state, grant bookkeeping and the operation/result
  // registers all advance together; reset discards any in-flight operation.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      req_q        <= '0;
      rsp_result_q <= '0;
      rsp_zf_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      rsp_result_q <= rsp_result_d;
      rsp_zf_q     <= rsp_zf_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, capture the ALU in EXEC, wait
  // for the granted requester's response handshake in RESP.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_d        = req_q;
    rsp_result_d = rsp_result_q;
    rsp_zf_d     = rsp_zf_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_ok) begin
          state_d      = ARB_EXEC;
          last_grant_d = grant_idx;
          grant_d      = grant_idx;
          req_d.op1    = grant_idx ? bus.i_op1_1  : bus.i_op1_0;
          req_d.op2    = grant_idx ? bus.i_op2_1  : bus.i_op2_0;
          req_d.ctrl   = grant_idx ? bus.i_ctrl_1 : bus.i_ctrl_0;
        end
      end
      ARB_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zf_d     = alu_zero;
        state_d      = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_ready_g) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Outputs: ready only in IDLE for the picked requester, response valid only
  // in RESP for the granted one; result and flag come straight from flops.
  always_comb begin
    bus.o_req_ready_0 = grant_ok && !grant_idx;
    bus.o_req_ready_1 = grant_ok &&  grant_idx;
    bus.o_rsp_valid_0 = (state_q == ARB_RESP) && !grant_q;
    bus.o_rsp_valid_1 = (state_q == ARB_RESP) &&  grant_q;
    bus.o_rsp_result  = rsp_result_q;
    bus.o_rsp_zf      = rsp_zf_q;
    bus.o_busy        = (state_q != ARB_IDLE);
    bus.o_last_grant  = last_grant_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a table of single operations, hand
// sequences for reset, tie-break, back-pressure and reset mid-operation, and a
// fairness soak. Responses are matched against a scoreboard queue.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic        idx;
    logic [31:0] result;
    logic        zf;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  int   checks = 0;
  int   failures = 0;
  int   rsp_count = 0;

  exp_t sb[$];
  exp_t exp_pend_0;
  exp_t exp_pend_1;
  vec_t vecs[10];

  alu_arbiter_if bus_if ();

  alu_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("ready_exclusive", 32'(bus_if.o_req_ready_0 & bus_if.o_req_ready_1), 32'd0);
      check("rsp_valid_exclusive", 32'(bus_if.o_rsp_valid_0 & bus_if.o_rsp_valid_1), 32'd0);
      if (bus_if.i_req_valid_0 && bus_if.o_req_ready_0) sb.push_back(exp_pend_0);
      if (bus_if.i_req_valid_1 && bus_if.o_req_ready_1) sb.push_back(exp_pend_1);
      if ((bus_if.o_rsp_valid_0 && bus_if.i_rsp_ready_0) ||
          (bus_if.o_rsp_valid_1 && bus_if.i_rsp_ready_1)) begin
        check("rsp_has_pending_req", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_idx", 32'(bus_if.o_rsp_valid_1), 32'(e.idx));
          check("rsp_result", bus_if.o_rsp_result, e.result);
          check("rsp_zf", 32'(bus_if.o_rsp_zf), 32'(e.zf));
          rsp_count++;
        end
      end
    end
  end

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!bus_if.o_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", 32'(ok), 32'd1);
  endtask

  task automatic drive_req(input logic r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
    if (r) begin
      bus_if.i_op1_1 = a; bus_if.i_op2_1 = b; bus_if.i_ctrl_1 = c;
      bus_if.i_req_valid_1 = 1'b1;
    end else begin
      bus_if.i_op1_0 = a; bus_if.i_op2_0 = b; bus_if.i_ctrl_0 = c;
      bus_if.i_req_valid_0 = 1'b1;
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    logic got;
    e = '{v.req, v.res, v.zf};
    if (v.req) exp_pend_1 = e; else exp_pend_0 = e;
    bus_if.i_rsp_ready_0 = 1'b1;
    bus_if.i_rsp_ready_1 = 1'b1;
    drive_req(v.req, v.op1, v.op2, v.ctrl);
    #1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (v.req ? bus_if.o_req_ready_1 : bus_if.o_req_ready_0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("vec_accepted", 32'(got), 32'd1);
    tick();
    bus_if.i_req_valid_0 = 1'b0;
    bus_if.i_req_valid_1 = 1'b0;
    drain();
  endtask

  // Soak operands: requester 0 adds, requester 1 subtracts from 1000.
  task automatic load_soak(input logic r, input int k);
    logic [31:0] a, b, res;
    if (r) begin
      a = 32'd1000; b = 32'(k * 7); res = a - b;
      drive_req(1'b1, a, b, ALU_SUB);
      exp_pend_1 = '{1'b1, res, res == 32'd0};
    end else begin
      a = 32'(k * 3 + 1); b = 32'(k + 100); res = a + b;
      drive_req(1'b0, a, b, ALU_ADD);
      exp_pend_0 = '{1'b0, res, res == 32'd0};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, k0, k1, accepts, last_c, rsp_base;
    logic exp_g, acc_now, acc_idx;

    vecs[0] = '{1'b0, 32'h0000_1234, 32'h0000_5678, 4'b1111,  32'h0000_0000, 1'b1};
    vecs[1] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD,  32'h8000_0000, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_ADD,  32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0001, ALU_SUB,  32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND,  32'h00F0_00F0, 1'b0};
    vecs[5] = '{1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, ALU_NOR,  32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0003, 32'h0000_0005, ALU_SOLT, 32'h0000_0001, 1'b0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, ALU_SOLT, 32'h0000_0001, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, ALU_SOLT, 32'h0000_0000, 1'b1};
    vecs[9] = '{1'b1, 32'hAAAA_5555, 32'hFFFF_0000, ALU_XOR,  32'h5555_5555, 1'b0};

    rst_n = 1'b0;
    bus_if.i_req_valid_0 = 1'b0; bus_if.i_op1_0 = '0; bus_if.i_op2_0 = '0;
    bus_if.i_ctrl_0 = '0; bus_if.i_rsp_ready_0 = 1'b0;
    bus_if.i_req_valid_1 = 1'b0; bus_if.i_op1_1 = '0; bus_if.i_op2_1 = '0;
    bus_if.i_ctrl_1 = '0; bus_if.i_rsp_ready_1 = 1'b0;
    exp_pend_0 = '{1'b0, 32'd0, 1'b0};
    exp_pend_1 = '{1'b1, 32'd0, 1'b0};
    repeat (3) tick();

    // Reset state, with a valid held high to show nothing is offered.
    bus_if.i_req_valid_0 = 1'b1;
    #1;
    check("rst_ready_0", 32'(bus_if.o_req_ready_0), 32'd0);
    check("rst_busy", 32'(bus_if.o_busy), 32'd0);
    check("rst_rsp_valid_0", 32'(bus_if.o_rsp_valid_0), 32'd0);
    check("rst_rsp_valid_1", 32'(bus_if.o_rsp_valid_1), 32'd0);
    check("rst_result", bus_if.o_rsp_result, 32'd0);
    check("rst_zf", 32'(bus_if.o_rsp_zf), 32'd0);
    check("rst_last_grant", 32'(bus_if.o_last_grant), 32'd1);
    bus_if.i_req_valid_0 = 1'b0;
    rst_n = 1'b1;

    // Single add with exact latency.
    exp_pend_0 = '{1'b0, 32'd12, 1'b0};
    bus_if.i_rsp_ready_0 = 1'b1;
    drive_req(1'b0, 32'd5, 32'd7, ALU_ADD);
    #1;
    check("add_ready_0_T", 32'(bus_if.o_req_ready_0), 32'd1);
    check("add_ready_1_T", 32'(bus_if.o_req_ready_1), 32'd0);
    tick();
    bus_if.i_req_valid_0 = 1'b0;
    #1;
    check("add_busy_T1", 32'(bus_if.o_busy), 32'd1);
    check("add_rsp_valid_T1", 32'(bus_if.o_rsp_valid_0), 32'd0);
    check("add_ready_T1", 32'(bus_if.o_req_ready_0), 32'd0);
    tick();
    check("add_rsp_valid_0_T2", 32'(bus_if.o_rsp_valid_0), 32'd1);
    check("add_rsp_valid_1_T2", 32'(bus_if.o_rsp_valid_1), 32'd0);
    check("add_result_T2", bus_if.o_rsp_result, 32'd12);
    check("add_zf_T2", 32'(bus_if.o_rsp_zf), 32'd0);
    tick();
    check("add_idle_T3", 32'(bus_if.o_busy), 32'd0);

    // Tie break straight after reset: requester 0 first, 1 at the next IDLE.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pend_0 = '{1'b0, 32'h0000_0000, 1'b1};
    exp_pend_1 = '{1'b1, 32'h0000_00FF, 1'b0};
    bus_if.i_rsp_ready_0 = 1'b1;
    bus_if.i_rsp_ready_1 = 1'b1;
    drive_req(1'b0, 32'd9, 32'd9, ALU_SUB);
    drive_req(1'b1, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
    #1;
    check("tie_ready_0", 32'(bus_if.o_req_ready_0), 32'd1);
    check("tie_ready_1", 32'(bus_if.o_req_ready_1), 32'd0);
    tick();
    bus_if.i_req_valid_0 = 1'b0;
    n = 0;
    while (!bus_if.o_req_ready_1 && n < 10) begin
      tick();
      n++;
    end
    check("tie_loser_wait", 32'(n), 32'd2);
    tick();
    bus_if.i_req_valid_1 = 1'b0;
    drain();

    // Table of single operations, alternating requesters.
    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Back-pressure on requester 1 while requester 0 waits.
    exp_pend_1 = '{1'b1, 32'd1, 1'b0};
    bus_if.i_rsp_ready_1 = 1'b0;
    bus_if.i_rsp_ready_0 = 1'b1;
    drive_req(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SOLT);
    #1;
    check("bp_ready_1", 32'(bus_if.o_req_ready_1), 32'd1);
    tick();
    bus_if.i_req_valid_1 = 1'b0;
    exp_pend_0 = '{1'b0, 32'd3, 1'b0};
    drive_req(1'b0, 32'd1, 32'd2, ALU_ADD);
    #1;
    check("bp_ready_0_exec", 32'(bus_if.o_req_ready_0), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid_1", 32'(bus_if.o_rsp_valid_1), 32'd1);
      check("bp_rsp_valid_0", 32'(bus_if.o_rsp_valid_0), 32'd0);
      check("bp_result", bus_if.o_rsp_result, 32'd1);
      check("bp_zf", 32'(bus_if.o_rsp_zf), 32'd0);
      check("bp_ready_0", 32'(bus_if.o_req_ready_0), 32'd0);
      tick();
    end
    bus_if.i_rsp_ready_1 = 1'b1;
    #1;
    check("bp_rsp_valid_hs", 32'(bus_if.o_rsp_valid_1), 32'd1);
    tick();
    check("bp_idle_after_hs", 32'(bus_if.o_busy), 32'd0);
    check("bp_ready_0_idle", 32'(bus_if.o_req_ready_0), 32'd1);
    tick();
    bus_if.i_req_valid_0 = 1'b0;
    drain();

    // Reset while in EXEC: operation dropped, outputs back to reset values.
    exp_pend_0 = '{1'b0, 32'h11, 1'b0};
    drive_req(1'b0, 32'h10, 32'h1, ALU_ADD);
    #1;
    check("rmid_ready_0", 32'(bus_if.o_req_ready_0), 32'd1);
    tick();
    bus_if.i_req_valid_0 = 1'b0;
    check("rmid_busy_exec", 32'(bus_if.o_busy), 32'd1);
    check("rmid_last_grant_exec", 32'(bus_if.o_last_grant), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rmid_busy", 32'(bus_if.o_busy), 32'd0);
    check("rmid_last_grant", 32'(bus_if.o_last_grant), 32'd1);
    check("rmid_rsp_valid_0", 32'(bus_if.o_rsp_valid_0), 32'd0);
    check("rmid_rsp_valid_1", 32'(bus_if.o_rsp_valid_1), 32'd0);
    check("rmid_result", bus_if.o_rsp_result, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rmid_no_rsp", 32'(bus_if.o_rsp_valid_0 | bus_if.o_rsp_valid_1), 32'd0);
    end

    // Fairness soak: both always valid, grants alternate every 3 cycles.
    rsp_base = rsp_count;
    bus_if.i_rsp_ready_0 = 1'b1;
    bus_if.i_rsp_ready_1 = 1'b1;
    k0 = 0; k1 = 0;
    load_soak(1'b0, k0);
    load_soak(1'b1, k1);
    #1;
    exp_g = 1'b0; accepts = 0; last_c = 0;
    for (int c = 0; c < 100 && accepts < 20; c++) begin
      acc_now = bus_if.o_req_ready_0 | bus_if.o_req_ready_1;
      acc_idx = bus_if.o_req_ready_1;
      if (acc_now) begin
        check("soak_grant", 32'(acc_idx), 32'(exp_g));
        if (accepts > 0) check("soak_spacing", 32'(c - last_c), 32'd3);
        exp_g = ~exp_g;
        last_c = c;
        accepts++;
      end
      tick();
      if (acc_now) begin
        if (acc_idx) begin k1++; load_soak(1'b1, k1); end
        else begin k0++; load_soak(1'b0, k0); end
      end
    end
    check("soak_accepts", 32'(accepts), 32'd20);
    bus_if.i_req_valid_0 = 1'b0;
    bus_if.i_req_valid_1 = 1'b0;
    drain();
    check("soak_completions", 32'(rsp_count - rsp_base), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit `alu` datapath between two independent requesters, such as the main execute path and an address/branch helper. Each requester has a valid/ready operand channel and a valid/ready response channel. A three-state FSM accepts one operation at a time using round-robin priority, executes it through one internal `alu` instance, and returns the registered result and zero flag to the granted requester only.

## Interface
- `WIDTH`, 32, operand/result width; fixed at 32 to match `alu`, not to be overridden.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_req_valid_0` / `i_req_valid_1`  in  1  requester r presents an operation.
- `o_req_ready_0` / `o_req_ready_1`  out  1  operation accepted this cycle; valid&&ready is a handshake.
- `i_op1_0`, `i_op2_0` / `i_op1_1`, `i_op2_1`  in  32  operands for requester r.
- `i_ctrl_0` / `i_ctrl_1`  in  4  ALU control code for requester r (shared `ALU_*` encoding).
- `o_rsp_valid_0` / `o_rsp_valid_1`  out  1  result for requester r is available.
- `i_rsp_ready_0` / `i_rsp_ready_1`  in  1  requester r consumes the result.
- `o_rsp_result`  out  32  registered ALU result; shared by both response channels and meaningful only alongside `o_rsp_valid_r`.
- `o_rsp_zf`  out  1  registered zero flag of `o_rsp_result`.
- `o_busy`  out  1  FSM is not in IDLE.
- `o_last_grant`  out  1  index of the most recently granted requester.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - `o_req_ready_r` is combinational and is asserted for at most one r.
  - If only one valid is asserted, that requester is granted.
  - If both are asserted, grant `~o_last_grant`.
  - On a grant: latch op1, op2, ctrl and the grant index; update `o_last_grant`; go to EXEC.
  - With no valid asserted, stay in IDLE.
- **EXEC:**
  - The `alu` sees only the latched operands; live inputs are ignored.
  - At the end of the cycle, capture the result and zf into the response registers; go to RESP.
- **RESP:**
  - Hold `o_rsp_valid_g` high for granted requester g. The other requester's rsp_valid stays 0.
  - Result and zf stay stable until `i_rsp_ready_g`.
  - On handshake, go to IDLE. `i_rsp_ready` of the non-granted requester is ignored.
- **Request channel in EXEC/RESP:** both `o_req_ready` are 0. Requesters may keep valid high or drop it; operations that were never accepted are not tracked.
- **Unknown ctrl code:** no error is raised. The `alu` default produces result 0, so zf = 1, and the result is returned normally.
- **Arithmetic:** all arithmetic lives inside `alu` (wrapping add/sub, signed SLT). The arbiter does not modify the result.
- **Reset values:**
  - state IDLE; `o_last_grant` = 1, so requester 0 wins the first tie.
  - `o_req_ready_*` = 0, `o_rsp_valid_*` = 0, `o_rsp_result` = 0, `o_rsp_zf` = 0, `o_busy` = 0.
  - Latched operand and ctrl registers = 0.
- **Reset mid-operation:** the in-flight operation is discarded and no response is issued. All outputs take their reset values on the next edge.

## Timing
- A request accepted at edge T gives `o_rsp_valid` high from T+2, i.e. two cycles of latency.
- If the response is consumed in the first RESP cycle, the next request can be accepted at T+3. Peak throughput is one operation per 3 cycles.
- The `o_req_ready` paths are combinational from `i_req_valid_*`, state and `o_last_grant`. No combinational path exists from `i_rsp_ready` to any output.
- Back-pressure: while `i_rsp_ready_g` = 0 the FSM stays in RESP indefinitely. The other requester waits.
- Simultaneous valid in IDLE: exactly one grant. The loser is granted next time both are valid, which bounds starvation to one operation.

## Structure
- FSM state encodings (2-bit `ARB_IDLE`/`ARB_EXEC`/`ARB_RESP`) go in the shared MIPS parameters header, next to the existing `ALU_*` codes.
- The module instantiates one existing `alu`, with inputs driven by the latched operand and ctrl registers.
- No further sub-module is needed. Arbitration is a 2-way round-robin inside the FSM.

## Test plan
- **Single add:** requester 0 sends op1=5, op2=7, ctrl=`ALU_ADD` (4'b0010), rsp_ready=1. Required: ready_0 in cycle T; rsp_valid_0 at T+2 with result 12, zf=0; rsp_valid_1 stays 0.
- **Tie break:** both valid after reset. Requester 0 sends `ALU_SUB` 9−9 and is granted first, returning result 0, zf=1. Requester 1 sends `ALU_OR` 0xF0|0x0F and is granted at the next IDLE, returning 0xFF.
- **Back-pressure:** requester 1 sends `ALU_SOLT` op1=0xFFFFFFFF, op2=1, rsp_ready_1 low for 4 cycles. Required: rsp_valid_1 and result 1 held stable for all 4 cycles; ready_0 = 0 throughout; IDLE resumes one cycle after the handshake.
- **Unknown code / overflow:** ctrl 4'b1111 gives result 0, zf=1. `ALU_ADD` 0x7FFFFFFF + 1 gives 0x80000000, zf=0.
- **Reset mid-operation:** drive `i_rst_n`=0 while the FSM is in EXEC. Required: the next edge returns to IDLE, no rsp_valid is asserted, and o_last_grant = 1.
- **Fairness soak:** both requesters always valid with rsp_ready high for 20 operations. Required: grants alternate 0,1,0,1,…, with one completion every 3 cycles.
